audio_dac_serializer: RTL and testbench
=======================================

# audio_dac_serializer

Transmit-side counterpart of the codec audio capture path: accepts 16-bit stereo sample pairs from the Nios II/Avalon domain through a valid/ready handshake, buffers them in a small FIFO, and serializes them onto the WM8731 DACDAT line in I2S format. The codec is bus master and drives BCLK and DACLRCK; this block is a slave that samples both on the system clock and drives DACDAT only.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel sample; range 8..32.
- FIFO_DEPTH, 8, stereo-pair entries; power of two, ≥ 2.

Ports:
- clk_clk  in  1  system clock, 50 MHz; must be ≥ 8× BCLK.
- reset_reset_n  in  1  asynchronous, active-low reset.
- sample_left  in  DATA_WIDTH  left sample, two's complement.
- sample_right  in  DATA_WIDTH  right sample, two's complement.
- sample_valid  in  1  pair offered this cycle.
- sample_ready  out  1  FIFO can accept; transfer when valid && ready.
- enable  in  1  playback enable.
- audio_interface_BCLK  in  1  codec bit clock, asynchronous.
- audio_interface_DACLRCK  in  1  codec frame clock, low = left, asynchronous.
- audio_interface_DACDAT  out  1  serial data to codec.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held.
- underflow_count  out  16  frames played as silence while enabled; saturates at 0xFFFF.

## Operation
- Reset values: DACDAT 0, sample_ready 0 while reset asserted then 1, fifo_level 0, underflow_count 0, shifter 0, channel state LEFT, enabled-latch 0.
- BCLK and DACLRCK pass through 2-FF synchronizers; a third register on BCLK gives edge detection (bclk_fall = prev 1, now 0).
- On every bclk_fall: sample synchronized LRCK as lr_now; compare with lr_prev (captured on previous bclk_fall).
  - lr_now ≠ lr_prev: channel boundary. Load shifter with the word for channel lr_now; drive its MSB on DACDAT; bit counter = DATA_WIDTH-1.
  - else if bit counter > 0: shift left, drive next bit, decrement.
  - else: drive 0 (padding for slots wider than DATA_WIDTH).
- Frame start = boundary with lr_now = 0 (left). At frame start: enabled-latch ← enable. If latch is 1 and FIFO non-empty, pop one pair; left word = entry.left, right held for the right boundary. If latch 1 and FIFO empty, both words = 0 and underflow_count += 1 (saturating). If latch 0, words = 0, no pop, no count.
- Right boundary loads the held right word; never pops.
- First boundary after reset that is a right boundary loads 0 (no pair held yet).
- enable changes take effect only at the next frame start; a frame in progress finishes unchanged.
- FIFO push: valid && ready. sample_ready = !full (0 in reset). Push and pop in the same cycle: level unchanged. Push into empty FIFO in the same cycle as a pop: pop sees empty → underflow; no bypass.
- Reset asserted mid-frame: all state cleared immediately, DACDAT 0; after release, output stays 0 until the first left boundary.

## Timing
- DACDAT updates 3 clk_clk cycles after the BCLK falling edge at the pin (2 sync + 1 register); at 50 MHz and BCLK ≤ 3.072 MHz, this leaves > 100 ns setup before the codec's rising-edge sample.
- I2S alignment: MSB is valid on the first BCLK rising edge after the rising edge on which the codec changed LRCK, i.e. one-BCLK delay from LRCK.
- FIFO pop occurs in the same cycle as the frame-start bclk_fall detection; fifo_level reflects it the next cycle.
- sample_ready is registered-combinational from full; a push is visible in fifo_level one cycle later.

## Structure
- Shared package audio_pkg: DATA_WIDTH default, stereo_sample_t struct {left, right}, channel enum {LEFT, RIGHT}, UNDERFLOW_MAX constant. The capture-side block uses the same package.
- One sub-module: audio_sample_fifo (synchronous FIFO of stereo_sample_t, depth FIFO_DEPTH, full/empty/level outputs). Synchronizers, edge detection, and shifter stay in the top.

## Test plan
- Reset then BCLK at 3.072 MHz and 48 kHz LRCK, enable=1, push {0x8001, 0x7FFE} → DACDAT bitstream left 1000…0001, right 0111…1110, MSB one BCLK after each LRCK edge, fifo_level 1→0.
- Push FIFO_DEPTH+1 pairs with no BCLK → sample_ready falls after 8 pushes, 9th not accepted, fifo_level 8.
- enable=1 with empty FIFO for 3 frames → DACDAT all 0, underflow_count 3; force the count to 0xFFFE, run 3 more frames → count 0xFFFF.
- Toggle enable 1→0 mid-left-channel → current frame completes with data; next frame silent, no pop, underflow_count unchanged.
- Assert reset_reset_n mid-right-channel → DACDAT 0 within one clk_clk, fifo_level 0; after release, first frame with a pushed pair plays correctly.
- DATA_WIDTH=16 with a 32-BCLK slot → bits 17..32 of each slot driven 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types for the codec capture and playback paths.
// Sample pair layout, channel encoding and the underflow counter ceiling.
package audio_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] left;
    logic [DEFAULT_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == UNDERFLOW_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous show-ahead FIFO of stereo sample pairs.
// Latency: write visible in level/rd_dat next cycle; pop takes effect next cycle.
// Backpressure: writes ignored while full, pops ignored while empty (no bypass).
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = stereo_sample_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_vld,
  input  entry_t                 wr_dat,
  input  logic                   rd_rdy,
  output entry_t                 rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: contents are only read while the level says valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S slave transmitter: buffers stereo pairs and shifts them onto DACDAT.
// Latency: DACDAT changes 3 clk_clk cycles after a BCLK falling edge at the pin.
// Backpressure: sample_ready drops while the FIFO is full; underflow plays silence.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [DATA_WIDTH-1:0]        sample_left,
  input  logic [DATA_WIDTH-1:0]        sample_right,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         enable,
  input  logic                         audio_interface_BCLK,
  input  logic                         audio_interface_DACLRCK,
  output logic                         audio_interface_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  underflow_count
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  logic [2:0]            bclk_sync;
  logic [1:0]            lr_sync;
  logic                  bclk_fall;
  channel_t              lr_now;
  channel_t              lr_prev;
  logic                  boundary;
  logic                  frame_start;
  logic                  play_pair;
  logic                  ready_en;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  pair_t                 wr_dat;
  pair_t                 rd_dat;
  logic                  en_latch;
  logic [DATA_WIDTH-1:0] held_right;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         bit_cnt;
  logic                  dacdat_q;
  logic [15:0]           underflow_q;

  assign bclk_fall   = bclk_sync[2] & ~bclk_sync[1];
  assign lr_now      = lr_sync[1] ? RIGHT : LEFT;
  assign boundary    = bclk_fall && (lr_now != lr_prev);
  assign frame_start = boundary && (lr_now == LEFT);
  // The enable seen at frame start becomes the latch value for this frame.
  assign play_pair   = enable && !fifo_empty;
  assign pop         = frame_start && play_pair;

  assign sample_ready = ready_en && !fifo_full;
  assign push         = sample_valid && sample_ready;
  assign wr_dat       = '{left: sample_left, right: sample_right};

  always_comb begin
    load_word = '0;
    if (lr_now == LEFT) begin
      if (play_pair) load_word = rd_dat.left;
    end else if (en_latch) begin
      load_word = held_right;
    end
  end

  audio_sample_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (pair_t)
  ) u_fifo (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .wr_vld (push),
    .wr_dat (wr_dat),
    .rd_rdy (pop),
    .rd_dat (rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync   <= '0;
      lr_sync     <= '0;
      lr_prev     <= LEFT;
      ready_en    <= 1'b0;
      en_latch    <= 1'b0;
      held_right  <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], audio_interface_BCLK};
      lr_sync   <= {lr_sync[0], audio_interface_DACLRCK};
      ready_en  <= 1'b1;

      if (frame_start) begin
        en_latch   <= enable;
        held_right <= play_pair ? rd_dat.right : '0;
        if (enable && fifo_empty) underflow_q <= sat_inc16(underflow_q);
      end

      if (bclk_fall) begin
        lr_prev <= lr_now;
        if (boundary) begin
          shift_q  <= load_word;
          dacdat_q <= load_word[DATA_WIDTH-1];
          bit_cnt  <= CW'(DATA_WIDTH-1);
        end else if (bit_cnt != '0) begin
          shift_q  <= shift_q << 1;
          dacdat_q <= shift_q[DATA_WIDTH-2];
          bit_cnt  <= bit_cnt - CW'(1);
        end else begin
          // Slot wider than the sample: pad with zeros.
          dacdat_q <= 1'b0;
        end
      end
    end
  end

  assign audio_interface_DACDAT = dacdat_q;
  assign underflow_count        = underflow_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: I2S playback, FIFO fill, underflow,
// enable timing and mid-frame reset, with 32-BCLK slots and 16-bit samples.
module tb_audio_dac_serializer;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        enable = 1'b0;
  logic        bclk = 1'b0;
  logic        lrck = 1'b1;
  logic        dacdat;
  logic [3:0]  fifo_level;
  logic [15:0] underflow_count;

  int total = 0;
  int bad = 0;

  audio_dac_serializer #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_clk                 (clk_clk),
    .reset_reset_n           (reset_reset_n),
    .sample_left             (sample_left),
    .sample_right            (sample_right),
    .sample_valid            (sample_valid),
    .sample_ready            (sample_ready),
    .enable                  (enable),
    .audio_interface_BCLK    (bclk),
    .audio_interface_DACLRCK (lrck),
    .audio_interface_DACDAT  (dacdat),
    .fifo_level              (fifo_level),
    .underflow_count         (underflow_count)
  );

  always #10 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk_clk);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    @(negedge clk_clk);
    sample_valid = 1'b0;
  endtask

  // n BCLK periods with LRCK = lr; LRCK changes on the rising edge, DACDAT is
  // captured just before the following rising edge (where the codec samples).
  task automatic slot(input logic lr, input int n, input logic [31:0] exp,
                      input string tag, input int en_off_at);
    logic [31:0] got;
    got = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_clk);
      if (i == en_off_at) enable = 1'b0;
      bclk = 1'b1;
      lrck = lr;
      repeat (8) @(negedge clk_clk);
      bclk = 1'b0;
      repeat (8) @(negedge clk_clk);
      got = {got[30:0], dacdat};
    end
    check(tag, got, exp);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input string tag);
    slot(1'b0, 32, {l, 16'h0000}, {tag, "_left"}, -1);
    slot(1'b1, 32, {r, 16'h0000}, {tag, "_right"}, -1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_clk);
    check("rst_dacdat", 32'(dacdat), 32'h0);
    check("rst_ready", 32'(sample_ready), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_underflow", 32'(underflow_count), 32'h0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    check("ready_after_rst", 32'(sample_ready), 32'h1);

    // Basic playback; the first boundary after reset is a right one and is silent
    enable = 1'b1;
    push_pair(16'h8001, 16'h7FFE);
    @(negedge clk_clk);
    check("level_after_push", 32'(fifo_level), 32'h1);
    slot(1'b1, 32, 32'h0, "prime_right", -1);
    frame(16'h8001, 16'h7FFE, "pair1");
    check("level_after_pop", 32'(fifo_level), 32'h0);
    check("underflow_after_pair1", 32'(underflow_count), 32'h0);

    // Underflow: three enabled frames with an empty FIFO
    for (int f = 0; f < 3; f++) frame(16'h0000, 16'h0000, "underflow");
    check("underflow_3", 32'(underflow_count), 32'h3);

    // enable dropped mid-left: frame completes, next frame silent, no pop/count
    push_pair(16'h1234, 16'hABCD);
    push_pair(16'h5A5A, 16'hC3C3);
    @(negedge clk_clk);
    check("level_two", 32'(fifo_level), 32'h2);
    slot(1'b0, 32, 32'h12340000, "disable_left", 8);
    slot(1'b1, 32, 32'hABCD0000, "disable_right", -1);
    check("level_after_disable", 32'(fifo_level), 32'h1);
    frame(16'h0000, 16'h0000, "disabled");
    check("level_held_disabled", 32'(fifo_level), 32'h1);
    check("underflow_held_disabled", 32'(underflow_count), 32'h3);

    // Re-enable, drain, then saturate the underflow counter
    enable = 1'b1;
    frame(16'h5A5A, 16'hC3C3, "pair2");
    check("level_after_pair2", 32'(fifo_level), 32'h0);
    @(negedge clk_clk);
    force dut.underflow_q = 16'hFFFE;
    @(negedge clk_clk);
    release dut.underflow_q;
    for (int f = 0; f < 3; f++) frame(16'h0000, 16'h0000, "saturate");
    check("underflow_saturated", 32'(underflow_count), 32'hFFFF);

    // Fill with BCLK idle: 8 accepted, 9th refused
    for (int i = 0; i < 8; i++) push_pair(16'h00F0 + 16'(i), 16'hFFFF);
    @(negedge clk_clk);
    check("level_full", 32'(fifo_level), 32'h8);
    check("ready_full", 32'(sample_ready), 32'h0);
    push_pair(16'hDEAD, 16'hBEEF);
    @(negedge clk_clk);
    check("level_after_ninth", 32'(fifo_level), 32'h8);

    // Reset in the middle of a right slot that is driving ones
    slot(1'b0, 32, 32'h00F00000, "prereset_left", -1);
    check("level_prereset", 32'(fifo_level), 32'h7);
    slot(1'b1, 10, 32'h000003FF, "prereset_right_part", -1);
    check("dacdat_prereset", 32'(dacdat), 32'h1);
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    check("dacdat_in_reset", 32'(dacdat), 32'h0);
    check("level_in_reset", 32'(fifo_level), 32'h0);
    check("underflow_in_reset", 32'(underflow_count), 32'h0);
    check("ready_in_reset", 32'(sample_ready), 32'h0);
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    push_pair(16'h9669, 16'h0FF0);
    slot(1'b1, 22, 32'h0, "postreset_right_rest", -1);
    frame(16'h9669, 16'h0FF0, "postreset");
    check("level_postreset", 32'(fifo_level), 32'h0);
    check("underflow_postreset", 32'(underflow_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
